// File: rtl/bk_port_pkg.sv
// Shared bit layout, constants and types for the BK 177714 mouse/joystick port.
package bk_port_pkg;

  // Bit positions in the 16-bit word read from 177714 in mouse mode.
  localparam int UP    = 0;
  localparam int RIGHT = 1;
  localparam int DOWN  = 2;
  localparam int LEFT  = 3;
  localparam int BTN_L = 5;
  localparam int BTN_R = 6;
  // Enable bit position in the CPU write word.
  localparam int ENA   = 3;

  localparam int ACCEL_THRESH = 16;
  localparam int ACC_W_DEF    = 10;

  typedef logic signed [ACC_W_DEF-1:0] acc_t;
  typedef logic signed [8:0]           delta_t;

  // hps_io carries each 9-bit delta as a separate sign bit plus a low byte.
  function automatic delta_t pkt_delta(input logic sign, input logic [7:0] mag);
    return {sign, mag};
  endfunction

  function automatic logic accel_hit(input delta_t d);
    return (d >= ACCEL_THRESH) || (d <= -ACCEL_THRESH);
  endfunction

endpackage

// File: rtl/mouse_axis.sv
// One motion axis: saturating accumulator, optional acceleration (MOUSE_ACCEL_EN)
// and the step engine that turns accumulated motion into pos/neg direction bits.
module mouse_axis
  import bk_port_pkg::*;
#(
  parameter int STEP_THRESH = 4,
  parameter int ACC_W       = ACC_W_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic signed [8:0] delta,
  input  logic              delta_vld,
  input  logic              enable,
  input  logic              clr_acc,
  input  logic              clr_dir,
  output logic              pos,
  output logic              neg
);

  // Wide enough for acc +/- a step plus a doubled delta without overflow.
  localparam int SUM_W = ((ACC_W > 11) ? ACC_W : 11) + 2;
  typedef logic signed [SUM_W-1:0] sum_t;

  localparam sum_t ACC_MAX = sum_t'((2 ** (ACC_W - 1)) - 1);
  localparam sum_t THRESH  = sum_t'(STEP_THRESH);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  sum_t acc_w;
  sum_t delta_w;
  sum_t delta_s;
  sum_t sum;
  logic idle;
  logic step_pos;
  logic step_neg;

  function automatic sum_t clamp(input sum_t v);
    if (v > ACC_MAX) return ACC_MAX;
    if (v < -ACC_MAX) return -ACC_MAX;
    return v;
  endfunction

  assign acc_w   = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc};
  assign delta_w = {{(SUM_W-9){delta[8]}}, delta};

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
`ifdef MOUSE_ACCEL_EN
    delta_s = accel_hit(delta) ? clamp(delta_w <<< 1) : clamp(delta_w);
`else
    delta_s = clamp(delta_w);
`endif
    idle     = enable & ~clr_dir & ~pos & ~neg;
    step_pos = idle && (acc_w >= THRESH);
    step_neg = idle && (acc_w <= -THRESH);
    sum      = acc_w;
    if (step_pos) sum = sum - THRESH;
    if (step_neg) sum = sum + THRESH;
    if (delta_vld && enable) sum = sum + delta_s;
    acc_nxt  = clr_acc ? '0 : ACC_W'(clamp(sum));
  end

  // NOTE: non-blocking updates so the step engine and accumulator both see the pre-edge acc.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc <= '0;
      pos <= 1'b0;
      neg <= 1'b0;
    end else begin
      acc <= acc_nxt;
      pos <= ~clr_dir & (pos | step_pos);
      neg <= ~clr_dir & (neg | step_neg);
    end
  end

endmodule

// File: rtl/mouse_port.sv
// Register 177714: merges joystick and PS/2 mouse into the CPU read word and
// decodes enable/acknowledge writes. Optional MOUSE_ACCEL_EN doubles large deltas.
module mouse_port
  import bk_port_pkg::*;
#(
  parameter int STEP_THRESH = 4,
  parameter int ACC_W       = ACC_W_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  input  logic [15:0] joystick,
  input  logic        port_sel,
  input  logic        bus_stb,
  input  logic        bus_we,
  input  logic [1:0]  bus_wtbt,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout
);

  logic       tog_q;
  logic       wr_q;
  logic       enable;
  logic       mode;
  logic [1:0] btn;
  logic       new_pkt;
  logic       wr;
  logic       wr_rise;
  logic       enable_eff;
  logic       up, right, down, left;
  logic [6:0] state;
  logic       unused_bits;

  assign new_pkt = ps2_mouse[24] ^ tog_q;
  assign wr      = port_sel & bus_stb & bus_we & bus_wtbt[0];
  assign wr_rise = wr & ~wr_q;
  // A packet arriving with the enabling write is already accumulated.
  assign enable_eff = wr_rise ? bus_din[ENA] : enable;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tog_q  <= ps2_mouse[24];
      wr_q   <= 1'b0;
      enable <= 1'b0;
      mode   <= 1'b0;
      btn    <= 2'b00;
    end else begin
      tog_q  <= ps2_mouse[24];
      wr_q   <= wr;
      enable <= enable_eff;
      if (new_pkt) begin
        btn  <= ps2_mouse[1:0];
        mode <= 1'b1;
      end else if (|joystick) begin
        mode <= 1'b0;
      end
    end
  end

  mouse_axis #(.STEP_THRESH(STEP_THRESH), .ACC_W(ACC_W)) u_axis_x (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .delta     (pkt_delta(ps2_mouse[4], ps2_mouse[15:8])),
    .delta_vld (new_pkt),
    .enable    (enable_eff),
    .clr_acc   (wr_rise & ~bus_din[ENA]),
    .clr_dir   (wr_rise),
    .pos       (right),
    .neg       (left)
  );

  mouse_axis #(.STEP_THRESH(STEP_THRESH), .ACC_W(ACC_W)) u_axis_y (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .delta     (pkt_delta(ps2_mouse[5], ps2_mouse[23:16])),
    .delta_vld (new_pkt),
    .enable    (enable_eff),
    .clr_acc   (wr_rise & ~bus_din[ENA]),
    .clr_dir   (wr_rise),
    .pos       (up),
    .neg       (down)
  );

  always_comb begin
    state        = '0;
    state[UP]    = up;
    state[RIGHT] = right;
    state[DOWN]  = down;
    state[LEFT]  = left;
    state[BTN_L] = btn[0];
    state[BTN_R] = btn[1];
  end

  always_comb begin
    bus_dout = '0;
    if (port_sel) bus_dout = mode ? {9'd0, state} : joystick;
  end

  assign unused_bits = ^{bus_din[15:4], bus_din[2:0], bus_wtbt[1],
                         ps2_mouse[7:6], ps2_mouse[3:2]};

endmodule

// File: doc/mouse_port.md
# mouse_port

Peripheral port controller for register 177714. It merges the hps_io joystick word and the PS/2 mouse packet stream into the 16-bit value the CPU reads on `port_sel`. PS/2 motion is accumulated and quantised into BK-style direction bits, and software writes handle acknowledge and enable. In the top level it sits upstream of the `cpu_din` OR-tree, in parallel with the PSG write path that shares the same select.

## Interface
Parameters:
- `STEP_THRESH`, default 4: motion counts per direction step, per axis; range 1..63.
- `ACC_W`, default 10: signed accumulator width per axis.

Ports:
- `clk_sys` in 1: system clock; all logic on posedge.
- `reset` in 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `ps2_mouse` in 25: hps_io mouse packet. Bit24 is the toggle; [1:0] are R/L buttons; [4],[15:8] are dx; [5],[23:16] are dy (9-bit two's complement).
- `joystick` in 16: OR of both joystick words.
- `port_sel` in 1: CPU peripheral select 2 (177714).
- `bus_stb` in 1: bus strobe (din | dout).
- `bus_we` in 1: write cycle.
- `bus_wtbt` in 2: byte enables; [0] is the low byte.
- `bus_din` in 16: CPU write data.
- `bus_dout` out 16: read data; 0 when `port_sel`=0.

## Operation
- Packet detect: register `ps2_mouse[24]`. A new packet is flagged when the registered copy differs from the live bit.
- On a new packet:
  - latch buttons into state[6] (R) and state[5] (L);
  - set `mode`=1 (mouse);
  - add dx to `acc_x` and dy to `acc_y`, both sign-extended to `ACC_W`.
  - Accumulation is saturating: clamp to ±(2^(ACC_W-1)-1) and never wrap.
  - Accumulation happens only while `enable`=1. When `enable`=0 the deltas are discarded.
- Joystick: any nonzero `joystick` bit sets `mode`=0 in that cycle. If a packet arrives in the same cycle, the mouse wins.
- Step engine, per axis, while `enable`=1 and both of that axis's direction bits are clear:
  - Y: if `acc_y` ≥ `STEP_THRESH`, set bit0 (up) and subtract `STEP_THRESH`. If `acc_y` ≤ −`STEP_THRESH`, set bit2 (down) and add `STEP_THRESH`.
  - X: same rule on `acc_x`, using bit1 (right) and bit3 (left).
  - At most one step per axis per cycle.
- Write decode: qualifier is `port_sel & bus_stb & bus_we & bus_wtbt[0]`, acting on its rising edge only (one action per bus cycle).
  - Load `enable` ← `bus_din[3]`.
  - Always clear state[3:0].
  - If `bus_din[3]`=0, also clear both accumulators.
- Simultaneous write and packet: the write's clear takes priority for state[3:0]. The packet's accumulation still applies if the new `enable` is 1.
- Read data: `bus_dout` = `port_sel` ? (`mode` ? {9'd0, state[6:0]} : `joystick`) : 16'd0.
  - Combinational from registered state; no read side effects.
  - state[4] always reads 0.
- Reset values: state 0, `acc_x` 0, `acc_y` 0, `enable` 0, `mode` 0, toggle register ← current `ps2_mouse[24]` (no spurious packet after reset), `bus_dout` 0.

## Timing
- Packet toggle visible at cycle N → accumulators and buttons updated at N+1 → direction bit set at N+2 at the earliest.
- Write rising edge at cycle N → `enable` and clears take effect at N+1.
- A full-speed packet stream (one per cycle) must be absorbed without loss; saturation bounds accumulator growth.
- Reset asserted mid-accumulation discards all pending motion in the next cycle.

## Configuration
- `MOUSE_ACCEL_EN`:
  - Defined: a packet delta with magnitude ≥ 16 is doubled (shift left 1, then saturated) before accumulation.
  - Undefined: deltas are accumulated 1:1.
- No other behaviour changes.

## Structure
- Package `bk_port_pkg` holds:
  - bit-position constants for the 177714 layout: UP=0, RIGHT=1, DOWN=2, LEFT=3, ENA=3, BTN_L=5, BTN_R=6;
  - the accel threshold 16;
  - a typedef for the signed accumulator.
- One sub-module, `mouse_axis`, instantiated twice (X and Y). It contains the saturating accumulator, the optional accel, and the step engine.
  - Inputs: `delta` (9-bit), `delta_vld`, `enable`, `clr_acc`, `clr_dir`.
  - Outputs: the `pos` and `neg` direction bits.

## Test plan
- Reset, then read with `port_sel`=1 and `joystick`=0: `bus_dout`=0. Set `joystick`=16'h0011: `bus_dout`=16'h0011.
- Write 16'h0008 (enable), then one packet with dy=+9 and `STEP_THRESH`=4: bit0 set 2 cycles after the toggle, `acc_y`=5. Write 16'h0008 again: bit0 clears, then re-sets next cycle (`acc_y`→1).
- Packet with dx=−3 while enabled: no step. A second packet with dx=−2: bit3 sets and `acc_x`=−1.
- With `enable`=0, packet with dx=+100 and L button: bits[3:0] stay 0, bit5=1, `bus_dout`=16'h0020.
- Packet stream of 200 × dy=+255 with `ACC_W`=10: `acc_y` saturates at 511, with no wrap to negative.
- Write and packet in the same cycle with dy=+8: state[3:0] cleared at N+1, then bit0 set at N+2. Under `MOUSE_ACCEL_EN`, dy=+20 accumulates 40.
